// File: rtl/req_tracker4.sv
// req_tracker4: per-channel pending-request counters that drive a 4-way
// fixed-priority selector, then capture and hold its one-hot grant.
// Ports: clock, reset (async, active-low);
//   req_in[3:0] request events, ps_gnt[3:0] selector grant,
//   done release pulse, ovf_clr sticky-overflow clear;
//   ps_req[3:0]/ps_en to selector, gnt_valid/gnt_oh[3:0]/gnt_id[1:0]
//   held grant, ovf[3:0] sticky drop flags, timeout forced-release pulse.
// Params: CNT_W counter width, TIMEOUT hold limit (1..255).
// Optional macro HOLD_TIMEOUT_EN: force release after TIMEOUT BUSY cycles.
module req_tracker4 #(
    parameter int CNT_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req_in,
    input  logic [3:0] ps_gnt,
    input  logic       done,
    input  logic       ovf_clr,
    output logic [3:0] ps_req,
    output logic       ps_en,
    output logic       gnt_valid,
    output logic [3:0] gnt_oh,
    output logic [1:0] gnt_id,
    output logic [3:0] ovf,
    output logic       timeout
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("req_tracker4: TIMEOUT must be 1..255");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] PMAX = '1;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] pend   [4];
    logic [CNT_W-1:0] pend_n [4];
    logic [3:0]       ovf_set;
    logic [3:0]       cap;
    logic [3:0]       sel_oh;
    logic [1:0]       sel_id;
    logic             take;
    logic             force_rel;
    logic             rel;

    always_comb begin
        ps_req = '0;
        for (int i = 0; i < 4; i++)
            ps_req[i] = (pend[i] != '0);
    end

    assign ps_en = (state == IDLE) && (ps_req != 4'b0);

    // Grants on channels with nothing pending are masked off.
    assign cap  = ps_en ? (ps_gnt & ps_req) : 4'b0;
    assign take = (cap != 4'b0);

    // Highest set bit wins if the selector ever returns non-one-hot.
    always_comb begin
        sel_oh = 4'b0;
        sel_id = 2'd0;
        if (cap[3]) begin
            sel_oh = 4'b1000;
            sel_id = 2'd3;
        end else if (cap[2]) begin
            sel_oh = 4'b0100;
            sel_id = 2'd2;
        end else if (cap[1]) begin
            sel_oh = 4'b0010;
            sel_id = 2'd1;
        end else if (cap[0]) begin
            sel_oh = 4'b0001;
            sel_id = 2'd0;
        end
    end

`ifdef HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       expire;

    // Expires on the TIMEOUT-th BUSY edge; done on that edge wins.
    assign expire    = (state == BUSY) &&
                       (hold_cnt == 8'(TIMEOUT - 1));
    assign force_rel = expire && !done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            timeout <= force_rel;
            if (take)
                hold_cnt <= 8'd0;
            else if (state == BUSY)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign rel = (state == BUSY) && (done || force_rel);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (take) state_n = BUSY;
            BUSY: if (rel)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_valid <= 1'b0;
            gnt_oh    <= 4'b0;
            gnt_id    <= 2'd0;
        end else if (take) begin
            gnt_valid <= 1'b1;
            gnt_oh    <= sel_oh;
            gnt_id    <= sel_id;
        end else if (rel) begin
            gnt_valid <= 1'b0;
            gnt_oh    <= 4'b0;
        end
    end

    // A capture never hits an empty counter, so no underflow guard.
    always_comb begin
        ovf_set = 4'b0;
        for (int i = 0; i < 4; i++) begin
            pend_n[i] = pend[i];
            if (req_in[i] && !(take && sel_oh[i])) begin
                if (pend[i] == PMAX)
                    ovf_set[i] = 1'b1;
                else
                    pend_n[i] = pend[i] + 1'b1;
            end else if (!req_in[i] && take && sel_oh[i]) begin
                pend_n[i] = pend[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++)
                pend[i] <= '0;
            ovf <= 4'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                pend[i] <= pend_n[i];
            ovf <= (ovf & ~{4{ovf_clr}}) | ovf_set;
        end
    end

endmodule

// File: tb/tb_req_tracker4.sv
// tb_req_tracker4: directed bench for req_tracker4 with a
// fixed-priority selector model and a forcing override on ps_gnt.
module tb_req_tracker4;

    logic       clock;
    logic       reset;
    logic [3:0] req_in;
    logic [3:0] ps_gnt;
    logic       done;
    logic       ovf_clr;
    logic [3:0] ps_req;
    logic       ps_en;
    logic       gnt_valid;
    logic [3:0] gnt_oh;
    logic [1:0] gnt_id;
    logic [3:0] ovf;
    logic       timeout;

    logic       frc;
    logic [3:0] frc_val;
    logic [3:0] mdl;
    logic       seen;

    int checks   = 0;
    int failures = 0;

    req_tracker4 #(.CNT_W(2), .TIMEOUT(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .req_in   (req_in),
        .ps_gnt   (ps_gnt),
        .done     (done),
        .ovf_clr  (ovf_clr),
        .ps_req   (ps_req),
        .ps_en    (ps_en),
        .gnt_valid(gnt_valid),
        .gnt_oh   (gnt_oh),
        .gnt_id   (gnt_id),
        .ovf      (ovf),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        mdl = 4'b0;
        if (ps_en) begin
            if (ps_req[3])      mdl = 4'b1000;
            else if (ps_req[2]) mdl = 4'b0100;
            else if (ps_req[1]) mdl = 4'b0010;
            else if (ps_req[0]) mdl = 4'b0001;
        end
        ps_gnt = frc ? frc_val : mdl;
    end

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic release_grant();
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        req_in  = 4'b0;
        done    = 1'b0;
        ovf_clr = 1'b0;
        frc     = 1'b1;
        frc_val = 4'b0;
        seen    = 1'b0;
        repeat (2) step();
        chk("rst_ps_req", 8'(ps_req), 8'h0);
        chk("rst_ps_en", 8'(ps_en), 8'h0);
        chk("rst_valid", 8'(gnt_valid), 8'h0);
        chk("rst_oh", 8'(gnt_oh), 8'h0);
        chk("rst_id", 8'(gnt_id), 8'h0);
        chk("rst_ovf", 8'(ovf), 8'h0);
        chk("rst_tmo", 8'(timeout), 8'h0);
        reset = 1'b1;
        step();
        frc = 1'b0;

        // single request on channel 2
        req_in = 4'b0100;
        step();
        req_in = 4'b0;
        chk("sr_ps_req", 8'(ps_req), 8'h4);
        chk("sr_ps_en", 8'(ps_en), 8'h1);
        chk("sr_valid0", 8'(gnt_valid), 8'h0);
        step();
        chk("sr_valid1", 8'(gnt_valid), 8'h1);
        chk("sr_oh", 8'(gnt_oh), 8'h4);
        chk("sr_id", 8'(gnt_id), 8'h2);
        chk("sr_pend0", 8'(ps_req), 8'h0);
        chk("sr_busy_en", 8'(ps_en), 8'h0);
        step();
        chk("sr_hold", 8'(gnt_valid), 8'h1);
        release_grant();
        chk("sr_rel_valid", 8'(gnt_valid), 8'h0);
        chk("sr_rel_oh", 8'(gnt_oh), 8'h0);
        chk("sr_rel_id", 8'(gnt_id), 8'h2);
        release_grant();
        chk("idle_done_v", 8'(gnt_valid), 8'h0);
        chk("idle_done_en", 8'(ps_en), 8'h0);

        // priority and counting: 3,3,0,0
        frc = 1'b1;
        frc_val = 4'b0;
        req_in = 4'b1001;
        repeat (2) step();
        req_in = 4'b0;
        chk("pc_ps_req", 8'(ps_req), 8'h9);
        frc = 1'b0;
        step();
        chk("pc_v0", 8'(gnt_valid), 8'h1);
        chk("pc_id0", 8'(gnt_id), 8'h3);
        for (int k = 0; k < 3; k++) begin
            release_grant();
            chk("pc_gap", 8'(gnt_valid), 8'h0);
            chk("pc_gap_en", 8'(ps_en), 8'h1);
            step();
            chk("pc_v", 8'(gnt_valid), 8'h1);
            chk("pc_id", 8'(gnt_id), (k == 0) ? 8'h3 : 8'h0);
        end
        release_grant();
        chk("pc_empty", 8'(ps_req), 8'h0);

        // saturation with channel 0 held BUSY
        req_in = 4'b0001;
        step();
        req_in = 4'b0;
        step();
        chk("sat_hold_id", 8'(gnt_id), 8'h0);
        req_in = 4'b0010;
        repeat (3) step();
        chk("sat_ps_req", 8'(ps_req), 8'h2);
        chk("sat_no_ovf", 8'(ovf), 8'h0);
        step();
        req_in = 4'b0;
        chk("sat_ovf", 8'(ovf), 8'h2);
        chk("sat_busy", 8'(gnt_valid), 8'h1);
        chk("sat_busy_id", 8'(gnt_id), 8'h0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 8'(ovf), 8'h0);
        ovf_clr = 1'b1;
        req_in = 4'b0010;
        step();
        ovf_clr = 1'b0;
        req_in = 4'b0;
        chk("ovf_set_wins", 8'(ovf), 8'h2);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr2", 8'(ovf), 8'h0);

        // inc and capture together on channel 1 (pend stays 3)
        release_grant();
        chk("sim_idle", 8'(gnt_valid), 8'h0);
        req_in = 4'b0010;
        step();
        req_in = 4'b0;
        chk("sim_id", 8'(gnt_id), 8'h1);
        chk("sim_no_ovf", 8'(ovf), 8'h0);
        for (int k = 0; k < 3; k++) begin
            release_grant();
            chk("sim_gap", 8'(gnt_valid), 8'h0);
            step();
            chk("sim_v", 8'(gnt_valid), 8'h1);
            chk("sim_vid", 8'(gnt_id), 8'h1);
        end
        release_grant();
        chk("sim_empty", 8'(ps_req), 8'h0);

        // masking: grant on a channel with nothing pending
        frc = 1'b1;
        frc_val = 4'b0100;
        req_in = 4'b0001;
        step();
        req_in = 4'b0;
        chk("msk_ps_req", 8'(ps_req), 8'h1);
        chk("msk_ps_en", 8'(ps_en), 8'h1);
        repeat (2) step();
        chk("msk_nocap", 8'(gnt_valid), 8'h0);
        release_grant();
        chk("msk_done_v", 8'(gnt_valid), 8'h0);
        chk("msk_done_en", 8'(ps_en), 8'h1);
        frc = 1'b0;
        step();
        chk("msk_v", 8'(gnt_valid), 8'h1);
        chk("msk_oh", 8'(gnt_oh), 8'h1);
        release_grant();
        chk("msk_empty", 8'(ps_req), 8'h0);

        // non-one-hot grant: highest bit captured
        frc = 1'b1;
        frc_val = 4'b1111;
        req_in = 4'b0101;
        step();
        req_in = 4'b0;
        step();
        chk("noh_oh", 8'(gnt_oh), 8'h4);
        chk("noh_id", 8'(gnt_id), 8'h2);
        release_grant();
        step();
        chk("noh_oh2", 8'(gnt_oh), 8'h1);
        chk("noh_id2", 8'(gnt_id), 8'h0);
        release_grant();
        chk("noh_empty", 8'(ps_req), 8'h0);
        frc = 1'b0;

        // hold timeout
        req_in = 4'b1000;
        step();
        req_in = 4'b0;
        step();
        chk("tmo_cap", 8'(gnt_valid), 8'h1);
`ifdef HOLD_TIMEOUT_EN
        for (int k = 0; k < 3; k++) begin
            step();
            chk("tmo_held", 8'(gnt_valid), 8'h1);
            chk("tmo_quiet", 8'(timeout), 8'h0);
        end
        step();
        chk("tmo_rel", 8'(gnt_valid), 8'h0);
        chk("tmo_oh", 8'(gnt_oh), 8'h0);
        chk("tmo_pulse", 8'(timeout), 8'h1);
        step();
        chk("tmo_pulse_end", 8'(timeout), 8'h0);
        req_in = 4'b1000;
        step();
        req_in = 4'b0;
        step();
        repeat (3) step();
        chk("tmo_d_held", 8'(gnt_valid), 8'h1);
        release_grant();
        chk("tmo_d_rel", 8'(gnt_valid), 8'h0);
        chk("tmo_d_nopulse", 8'(timeout), 8'h0);
        step();
        chk("tmo_d_nopulse2", 8'(timeout), 8'h0);
`else
        for (int k = 0; k < 20; k++) begin
            step();
            seen = seen | timeout;
        end
        chk("notmo_held", 8'(gnt_valid), 8'h1);
        chk("notmo_pulse", 8'(seen), 8'h0);
        release_grant();
        chk("notmo_rel", 8'(gnt_valid), 8'h0);
`endif

        // asynchronous reset mid-BUSY with pend[2]=2
        frc = 1'b1;
        frc_val = 4'b0;
        req_in = 4'b0101;
        step();
        req_in = 4'b0100;
        repeat (2) step();
        req_in = 4'b0;
        chk("ar_ps_req", 8'(ps_req), 8'h5);
        frc_val = 4'b0100;
        step();
        chk("ar_busy", 8'(gnt_valid), 8'h1);
        chk("ar_id", 8'(gnt_id), 8'h2);
        chk("ar_pend", 8'(ps_req), 8'h5);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_ps_req0", 8'(ps_req), 8'h0);
        chk("ar_ps_en0", 8'(ps_en), 8'h0);
        chk("ar_valid0", 8'(gnt_valid), 8'h0);
        chk("ar_oh0", 8'(gnt_oh), 8'h0);
        chk("ar_id0", 8'(gnt_id), 8'h0);
        chk("ar_tmo0", 8'(timeout), 8'h0);
        step();
        reset = 1'b1;
        frc = 1'b0;
        step();
        chk("ar_post_req", 8'(ps_req), 8'h0);
        chk("ar_post_v", 8'(gnt_valid), 8'h0);
        req_in = 4'b1000;
        step();
        req_in = 4'b0;
        step();
        chk("ar_idle_v", 8'(gnt_valid), 8'h1);
        chk("ar_idle_id", 8'(gnt_id), 8'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
